// File: rtl/lc2k_pkg.sv
// Shared LC2K decode definitions: opcode and FSM encodings, instruction
// field positions and datapath widths.
package lc2k_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 3;

    localparam int unsigned OP_HI     = 24;
    localparam int unsigned OP_LO     = 22;
    localparam int unsigned REGA_HI   = 21;
    localparam int unsigned REGA_LO   = 19;
    localparam int unsigned REGB_HI   = 18;
    localparam int unsigned REGB_LO   = 16;
    localparam int unsigned DEST_HI   = 2;
    localparam int unsigned DEST_LO   = 0;
    localparam int unsigned OFFSET_HI = 15;
    localparam int unsigned OFFSET_LO = 0;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_NOR  = 3'd1,
        OP_LW   = 3'd2,
        OP_SW   = 3'd3,
        OP_BEQ  = 3'd4,
        OP_JALR = 3'd5,
        OP_HALT = 3'd6,
        OP_NOOP = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/lc2k_decode_if.sv
// Fetch-side handshake plus the decoded-field bus towards register file/execute.
interface lc2k_decode_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned PC_W       = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_instr;
    logic [PC_W-1:0]       in_pc;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [REG_ADDR_W-1:0] read_regA;
    logic [REG_ADDR_W-1:0] read_regB;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  CONTROL_ENABLE_REG_WRITE;
    logic [2:0]            ctrl_op;
    logic [DATA_W-1:0]     offset_ext;
    logic [PC_W-1:0]       out_pc;
    logic                  halted;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, read_regA, read_regB, write_reg,
               CONTROL_ENABLE_REG_WRITE, ctrl_op, offset_ext, out_pc, halted
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, read_regA, read_regB, write_reg,
               CONTROL_ENABLE_REG_WRITE, ctrl_op, offset_ext, out_pc, halted
    );
endinterface

// File: rtl/lc2k_instr_fields.sv
// Combinational LC2K field extraction: register indices, destination/write
// enable selection, source-usage flags for hazard checks, sign-extended offset.
module lc2k_instr_fields
    import lc2k_pkg::*;
(
    input  logic [DATA_W-1:0]     instr,
    output opcode_e               op,
    output logic [REG_ADDR_W-1:0] reg_a,
    output logic [REG_ADDR_W-1:0] reg_b,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic                  wr_en,
    output logic                  uses_reg_a,
    output logic                  uses_reg_b,
    output logic [DATA_W-1:0]     offset_ext
);
    logic unused_hi_bits;

    assign unused_hi_bits = ^instr[DATA_W-1:OP_HI+1];

    always_comb begin
        op         = opcode_e'(instr[OP_HI:OP_LO]);
        reg_a      = instr[REGA_HI:REGA_LO];
        reg_b      = instr[REGB_HI:REGB_LO];
        offset_ext = {{(DATA_W-OFFSET_HI-1){instr[OFFSET_HI]}}, instr[OFFSET_HI:OFFSET_LO]};
        write_reg  = '0;
        wr_en      = 1'b0;
        uses_reg_a = 1'b0;
        uses_reg_b = 1'b0;
        case (op)
            OP_ADD, OP_NOR: begin
                write_reg  = instr[DEST_HI:DEST_LO];
                wr_en      = 1'b1;
                uses_reg_a = 1'b1;
                uses_reg_b = 1'b1;
            end
            OP_LW, OP_JALR: begin
                write_reg  = instr[REGB_HI:REGB_LO];
                wr_en      = 1'b1;
                uses_reg_a = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                uses_reg_a = 1'b1;
                uses_reg_b = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/lc2k_decode.sv
// LC2K decode stage: single registered output slot with valid/ready on both
// sides, load-use bubble insertion, branch flush and sticky halt.
module lc2k_decode
    import lc2k_pkg::*;
#(
    parameter int unsigned PC_W = 16
) (
    input logic          clk,
    input logic          rst,
    lc2k_decode_if.slave bus
);
    opcode_e               f_op;
    logic [REG_ADDR_W-1:0] f_reg_a, f_reg_b, f_write_reg;
    logic                  f_wr_en, f_uses_a, f_uses_b;
    logic [DATA_W-1:0]     f_offset;

    lc2k_instr_fields u_fields (
        .instr      (bus.in_instr),
        .op         (f_op),
        .reg_a      (f_reg_a),
        .reg_b      (f_reg_b),
        .write_reg  (f_write_reg),
        .wr_en      (f_wr_en),
        .uses_reg_a (f_uses_a),
        .uses_reg_b (f_uses_b),
        .offset_ext (f_offset)
    );

    state_e                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [REG_ADDR_W-1:0] reg_a_q, reg_a_d;
    logic [REG_ADDR_W-1:0] reg_b_q, reg_b_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic                  wr_en_q, wr_en_d;
    opcode_e               ctrl_op_q, ctrl_op_d;
    logic [DATA_W-1:0]     offset_q, offset_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic                  pending_lw_q, pending_lw_d;
    logic [REG_ADDR_W-1:0] pending_dest_q, pending_dest_d;

    logic hazard, halt_held, transfer, in_ready, accept;

    always_comb begin
        // pending_lw tracks an lw sitting in the output slot; the dependent
        // instruction is held off until the slot has drained (the STALL cycle).
        hazard    = pending_lw_q && bus.in_valid &&
                    ((f_uses_a && (f_reg_a == pending_dest_q)) ||
                     (f_uses_b && (f_reg_b == pending_dest_q)));
        halt_held = out_valid_q && (ctrl_op_q == OP_HALT);
        transfer  = out_valid_q && bus.out_ready;
        in_ready  = (state_q != ST_HALTED) && !hazard && !halt_held &&
                    (!out_valid_q || bus.out_ready);
        accept    = bus.in_valid && in_ready;

        state_d        = state_q;
        out_valid_d    = out_valid_q;
        reg_a_d        = reg_a_q;
        reg_b_d        = reg_b_q;
        write_reg_d    = write_reg_q;
        wr_en_d        = wr_en_q;
        ctrl_op_d      = ctrl_op_q;
        offset_d       = offset_q;
        pc_d           = pc_q;
        pending_lw_d   = pending_lw_q;
        pending_dest_d = pending_dest_q;

        if (state_q != ST_HALTED) begin
            if (transfer) begin
                out_valid_d  = 1'b0;
                pending_lw_d = 1'b0;
            end
            if (accept) begin
                out_valid_d    = 1'b1;
                reg_a_d        = f_reg_a;
                reg_b_d        = f_reg_b;
                write_reg_d    = f_write_reg;
                wr_en_d        = f_wr_en;
                ctrl_op_d      = f_op;
                offset_d       = f_offset;
                pc_d           = bus.in_pc;
                pending_lw_d   = (f_op == OP_LW);
                pending_dest_d = f_reg_b;
            end
            case (state_q)
                ST_RUN:   if (hazard) state_d = ST_STALL;
                ST_STALL: state_d = ST_RUN;
                default:  ;
            endcase
            if (bus.flush) begin
                out_valid_d  = 1'b0;
                pending_lw_d = 1'b0;
                state_d      = ST_RUN;
            end
            if (transfer && (ctrl_op_q == OP_HALT)) begin
                state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            out_valid_q    <= 1'b0;
            reg_a_q        <= '0;
            reg_b_q        <= '0;
            write_reg_q    <= '0;
            wr_en_q        <= 1'b0;
            ctrl_op_q      <= OP_ADD;
            offset_q       <= '0;
            pc_q           <= '0;
            pending_lw_q   <= 1'b0;
            pending_dest_q <= '0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            reg_a_q        <= reg_a_d;
            reg_b_q        <= reg_b_d;
            write_reg_q    <= write_reg_d;
            wr_en_q        <= wr_en_d;
            ctrl_op_q      <= ctrl_op_d;
            offset_q       <= offset_d;
            pc_q           <= pc_d;
            pending_lw_q   <= pending_lw_d;
            pending_dest_q <= pending_dest_d;
        end
    end

    assign bus.in_ready                 = in_ready;
    assign bus.out_valid                = out_valid_q;
    assign bus.read_regA                = reg_a_q;
    assign bus.read_regB                = reg_b_q;
    assign bus.write_reg                = write_reg_q;
    assign bus.CONTROL_ENABLE_REG_WRITE = wr_en_q;
    assign bus.ctrl_op                  = ctrl_op_q;
    assign bus.offset_ext               = offset_q;
    assign bus.out_pc                   = pc_q;
    assign bus.halted                   = (state_q == ST_HALTED);
endmodule

// File: tb/tb_lc2k_decode.sv
// Bench for lc2k_decode: table vectors through a scoreboard, plus directed
// sequences for load-use, backpressure, flush, halt and reset.
module tb_lc2k_decode;

    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] pc;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  wr;
        logic        we;
        logic [2:0]  op;
        logic [31:0] off;
    } vec_t;

    typedef struct packed {
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  wr;
        logic        we;
        logic [2:0]  op;
        logic [31:0] off;
        logic [15:0] pc;
    } out_t;

    logic clk;
    logic rst;

    lc2k_decode_if #(.DATA_W(32), .REG_ADDR_W(3), .PC_W(16)) bus ();

    lc2k_decode #(.PC_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    out_t        sb[$];
    vec_t        tbl[8];

    function automatic out_t exp_of(input vec_t v);
        return '{v.ra, v.rb, v.wr, v.we, v.op, v.off, v.pc};
    endfunction

    function automatic out_t cur_out();
        return {bus.read_regA, bus.read_regB, bus.write_reg,
                bus.CONTROL_ENABLE_REG_WRITE, bus.ctrl_op, bus.offset_ext, bus.out_pc};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        out_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_out: got %h with nothing expected", cur_out());
            end else begin
                e = sb.pop_front();
                chk("decoded_fields", 64'(cur_out()), 64'(e));
            end
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at posedge+1 of the accepting edge with in_valid dropped.
    task automatic send(input vec_t v, output int unsigned waits);
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = v.instr;
        bus.in_pc    = v.pc;
        @(negedge clk);
        while (!bus.in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (bus.in_ready) begin
            sb.push_back(exp_of(v));
        end else begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        vec_t        v, v_lw, v_dep;
        int unsigned w;

        //        instr          pc       ra    rb    wr    we    op    off
        tbl[0] = '{32'h000A0003, 16'h0010, 3'd1, 3'd2, 3'd3, 1'b1, 3'd0, 32'h00000003};
        tbl[1] = '{32'h00650007, 16'h0011, 3'd4, 3'd5, 3'd7, 1'b1, 3'd1, 32'h00000007};
        tbl[2] = '{32'h009E8000, 16'h0012, 3'd3, 3'd6, 3'd6, 1'b1, 3'd2, 32'hFFFF8000};
        tbl[3] = '{32'h00CA0005, 16'h0013, 3'd1, 3'd2, 3'd0, 1'b0, 3'd3, 32'h00000005};
        tbl[4] = '{32'h0138FFFE, 16'h0014, 3'd7, 3'd0, 3'd0, 1'b0, 3'd4, 32'hFFFFFFFE};
        tbl[5] = '{32'h01540000, 16'h0015, 3'd2, 3'd4, 3'd4, 1'b1, 3'd5, 32'h00000000};
        tbl[6] = '{32'h01C07FFF, 16'h0016, 3'd0, 3'd0, 3'd0, 1'b0, 3'd7, 32'h00007FFF};
        tbl[7] = '{32'h001B1235, 16'h0017, 3'd3, 3'd3, 3'd5, 1'b1, 3'd0, 32'h00001235};
        v_lw   = '{32'h0081FFFF, 16'h0100, 3'd0, 3'd1, 3'd1, 1'b1, 3'd2, 32'hFFFFFFFF};
        v_dep  = '{32'h00080002, 16'h0101, 3'd1, 3'd0, 3'd2, 1'b1, 3'd0, 32'h00000002};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        idle(2);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_halted", 64'(bus.halted), 64'd0);
        chk("rst_fields", 64'(cur_out()), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        idle(1);

        // Independent instructions back to back: one accept per cycle.
        for (int i = 0; i < 8; i++) begin
            send(tbl[i], w);
            chk("throughput_wait", 64'(w), 64'd0);
        end
        idle(3);
        chk("table_drained", 64'(sb.size()), 64'd0);

        // Load-use: lw r1 followed by add reading r1.
        send(v_lw, w);
        bus.in_valid = 1'b1;
        bus.in_instr = v_dep.instr;
        bus.in_pc    = v_dep.pc;
        @(negedge clk);
        chk("lu_hazard_ready", 64'(bus.in_ready), 64'd0);
        chk("lu_lw_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lu_bubble_valid", 64'(bus.out_valid), 64'd0);
        chk("lu_bubble_ready", 64'(bus.in_ready), 64'd1);
        sb.push_back(exp_of(v_dep));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lu_add_valid", 64'(bus.out_valid), 64'd1);
        idle(2);

        // Backpressure: held output must not change for 3 cycles.
        bus.out_ready = 1'b0;
        v = tbl[1];
        v.pc = 16'h0200;
        send(v, w);
        bus.in_valid = 1'b1;
        bus.in_instr = tbl[3].instr;
        bus.in_pc    = 16'h0204;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_fields", 64'(cur_out()), 64'(exp_of(v)));
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        v = tbl[3];
        v.pc = 16'h0204;
        sb.push_back(exp_of(v));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        idle(2);

        // Flush of a held instruction.
        bus.out_ready = 1'b0;
        v = tbl[4];
        v.pc = 16'h0300;
        send(v, w);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        if (sb.size() > 0) void'(sb.pop_back());
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_held_valid", 64'(bus.out_valid), 64'd0);

        // Flush drops an instruction accepted on the same edge.
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = tbl[5].instr;
        bus.in_pc     = 16'h0304;
        bus.flush     = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        chk("flush_drop_valid", 64'(bus.out_valid), 64'd0);
        idle(1);

        // Flush clears the pending load so the dependent add is not held off.
        bus.out_ready = 1'b0;
        v = v_lw;
        v.pc = 16'h0310;
        send(v, w);
        bus.in_valid = 1'b1;
        bus.in_instr = v_dep.instr;
        bus.in_pc    = 16'h0314;
        bus.flush    = 1'b1;
        @(posedge clk); #1;
        if (sb.size() > 0) void'(sb.pop_back());
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_clr_pending", 64'(bus.in_ready), 64'd1);
        v = v_dep;
        v.pc = 16'h0314;
        sb.push_back(exp_of(v));
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(2);

        // Halt: sticky, ignores further input and flush.
        v = '{32'h01800000, 16'h0400, 3'd0, 3'd0, 3'd0, 1'b0, 3'd6, 32'h0};
        send(v, w);
        @(negedge clk);
        chk("halt_pre_halted", 64'(bus.halted), 64'd0);
        chk("halt_pre_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_instr = tbl[0].instr;
        bus.flush    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("halted_flag", 64'(bus.halted), 64'd1);
            chk("halted_in_ready", 64'(bus.in_ready), 64'd0);
            chk("halted_out_valid", 64'(bus.out_valid), 64'd0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_async_halted", 64'(bus.halted), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_halt_in_ready", 64'(bus.in_ready), 64'd1);
        idle(1);

        // Reset asserted during the load-use STALL cycle.
        send(v_lw, w);
        bus.in_valid = 1'b1;
        bus.in_instr = v_dep.instr;
        bus.in_pc    = v_dep.pc;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_stall_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_stall_halted", 64'(bus.halted), 64'd0);
        chk("rst_stall_fields", 64'(cur_out()), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall_in_ready", 64'(bus.in_ready), 64'd1);
        idle(1);
        send(tbl[0], w);
        chk("post_rst_wait", 64'(w), 64'd0);
        idle(3);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
